// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port, fixed-latency memory between instruction-fetch and data ports.
// Each access is IDLE (grant) -> ACC (LATENCY cycles) -> DONE (one-cycle ready pulse).
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              owner;
  logic              last_owner;
  logic [ADDR_W-1:0] addr_lat;
  logic [DATA_W-1:0] wdata_lat;
  logic              we_lat;
  logic              d_req;
  logic              grant;
  logic              grant_owner;
  logic              acc_last;

  assign d_req    = d_read | d_write;
  assign acc_last = (cnt == CNT_LAST);

  // When both ports are pending, the port that did not own the previous access wins.
  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    grant_owner = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!if_req || !last_owner)) begin
          grant       = 1'b1;
          grant_owner = 1'b1;
          state_nxt   = ACC;
        end else if (if_req) begin
          grant       = 1'b1;
          grant_owner = 1'b0;
          state_nxt   = ACC;
        end
      end
      ACC:     if (acc_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 4'd0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      addr_lat   <= '0;
      wdata_lat  <= '0;
      we_lat     <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      if (grant) begin
        owner     <= grant_owner;
        addr_lat  <= grant_owner ? d_addr : if_addr;
        wdata_lat <= d_wdata;
        we_lat    <= grant_owner & d_write;
        cnt       <= 4'd0;
      end
      // Memory read data is only valid in the final enabled cycle.
      if (state == ACC) begin
        cnt <= cnt + 4'd1;
        if (acc_last) begin
          last_owner <= owner;
          if (owner) begin
            d_ready <= 1'b1;
            if (!we_lat) d_rdata <= mem_rdata;
          end else begin
            if_ready <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end
      end
    end
  end

  assign mem_en    = (state == ACC);
  assign mem_we    = mem_en & we_lat;
  assign mem_addr  = addr_lat;
  assign mem_wdata = wdata_lat;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_req & ~d_ready;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: two instances (LATENCY 2 and 1) with a scoreboard of expected accesses.
module tb_unified_mem_arbiter;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0004: memf = 32'h2002_000A;
      32'h0000_0020: memf = 32'h0000_0055;
      default:       memf = {a[15:0], ~a[15:0]};
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_if_req, a_d_read, a_d_write;
  logic [31:0] a_if_addr, a_d_addr, a_d_wdata, a_mem_rdata;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
  logic        a_if_ready, a_d_ready, a_mem_en, a_mem_we, a_stall_if, a_stall_mem, a_busy;

  logic        b_if_req, b_d_read, b_d_write;
  logic [31:0] b_if_addr, b_d_addr, b_d_wdata, b_mem_rdata;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic        b_if_ready, b_d_ready, b_mem_en, b_mem_we, b_stall_if, b_stall_mem, b_busy;

  assign a_mem_rdata = a_mem_en ? memf(a_mem_addr) : 32'hBAD0_BAD0;
  assign b_mem_rdata = b_mem_en ? memf(b_mem_addr) : 32'hBAD0_BAD0;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ready(a_if_ready),
    .d_read(a_d_read), .d_write(a_d_write), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_ready(a_d_ready),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .stall_if(a_stall_if), .stall_mem(a_stall_mem), .busy(a_busy)
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .d_read(b_d_read), .d_write(b_d_write), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ready(b_d_ready),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .stall_if(b_stall_if), .stall_mem(b_stall_mem), .busy(b_busy)
  );

  // Instance selected for the shared completion checker.
  logic        sel;
  logic        s_mem_en, s_mem_we, s_if_ready, s_d_ready, s_stall_if, s_stall_mem;
  logic [31:0] s_mem_addr, s_mem_wdata, s_if_rdata, s_d_rdata;

  always_comb begin
    s_mem_en    = sel ? b_mem_en    : a_mem_en;
    s_mem_we    = sel ? b_mem_we    : a_mem_we;
    s_if_ready  = sel ? b_if_ready  : a_if_ready;
    s_d_ready   = sel ? b_d_ready   : a_d_ready;
    s_stall_if  = sel ? b_stall_if  : a_stall_if;
    s_stall_mem = sel ? b_stall_mem : a_stall_mem;
    s_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
    s_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
    s_if_rdata  = sel ? b_if_rdata  : a_if_rdata;
    s_d_rdata   = sel ? b_d_rdata   : a_d_rdata;
  end

  int          n_cmp = 0;
  int          n_err = 0;
  txn_t        sbq[$];
  logic [31:0] ird_exp [2];
  logic [31:0] drd_exp [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push(input logic port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.port  = port;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = we ? 32'h0 : memf(addr);
    sbq.push_back(t);
  endtask

  // Waits for the next completion on the selected instance; exp_k counts negedges from the call.
  task automatic wait_done(input int exp_k, input int lat);
    txn_t e;
    logic done;
    int   en_n;
    done = 1'b0;
    en_n = 0;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sbq[0];
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (s_mem_en) begin
        en_n++;
        chk("mem_addr", s_mem_addr, e.addr);
        chk1("mem_we", s_mem_we, e.we);
        if (e.we) chk("mem_wdata", s_mem_wdata, e.wdata);
      end
      chk1("stall", e.port ? s_stall_mem : s_stall_if, k < exp_k);
      if (s_if_ready || s_d_ready) begin
        done = 1'b1;
        void'(sbq.pop_front());
        chk1("ready_port", s_d_ready, e.port);
        chk1("ready_both", s_if_ready && s_d_ready, 1'b0);
        chk("latency", 32'(k), 32'(exp_k));
        chk("en_cycles", 32'(en_n), 32'(lat));
        if (e.port) begin
          if (!e.we) drd_exp[sel] = e.rdata;
          chk("d_rdata", s_d_rdata, drd_exp[sel]);
        end else begin
          ird_exp[sel] = e.rdata;
          chk("if_rdata", s_if_rdata, ird_exp[sel]);
        end
      end
    end
    chk1("done_in_budget", done, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {a_if_req, a_d_read, a_d_write, b_if_req, b_d_read, b_d_write} = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ird_exp[0] = 32'h0; ird_exp[1] = 32'h0;
    drd_exp[0] = 32'h0; drd_exp[1] = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel = 1'b0;
    {a_if_addr, a_d_addr, a_d_wdata, b_if_addr, b_d_addr, b_d_wdata} = '0;
    do_reset();

    chk1("rst_busy_a", a_busy, 1'b0);
    chk1("rst_mem_en_a", a_mem_en, 1'b0);
    chk1("rst_mem_we_a", a_mem_we, 1'b0);
    chk1("rst_if_ready_a", a_if_ready, 1'b0);
    chk1("rst_d_ready_a", a_d_ready, 1'b0);
    chk("rst_if_rdata_a", a_if_rdata, 32'h0);
    chk("rst_d_rdata_a", a_d_rdata, 32'h0);
    chk("rst_mem_addr_a", a_mem_addr, 32'h0);
    chk("rst_mem_wdata_a", a_mem_wdata, 32'h0);
    chk1("rst_busy_b", b_busy, 1'b0);
    chk1("rst_mem_en_b", b_mem_en, 1'b0);

    // IF read at 0x04
    a_if_req = 1'b1; a_if_addr = 32'h4;
    push(1'b0, 1'b0, 32'h4, 32'h0);
    wait_done(3, LAT_A);
    a_if_req = 1'b0;
    @(negedge clk);
    chk1("idle_after_if", a_busy, 1'b0);

    // data write, no IF request
    a_d_write = 1'b1; a_d_addr = 32'h100; a_d_wdata = 32'hDEAD_BEEF;
    push(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
    wait_done(3, LAT_A);
    a_d_write = 1'b0;
    @(negedge clk);

    // both pending after reset: IF first, then D
    do_reset();
    a_if_req = 1'b1; a_if_addr = 32'h40;
    a_d_read = 1'b1; a_d_addr  = 32'h200;
    push(1'b0, 1'b0, 32'h40, 32'h0);
    push(1'b1, 1'b0, 32'h200, 32'h0);
    wait_done(3, LAT_A);
    chk1("stall_mem_while_if", a_stall_mem, 1'b1);
    a_if_req = 1'b0;
    wait_done(4, LAT_A);
    a_d_read = 1'b0;
    @(negedge clk);

    // continuous requests on both ports alternate
    a_if_req = 1'b1; a_if_addr = 32'h80;
    a_d_read = 1'b1; a_d_addr  = 32'h300;
    push(1'b0, 1'b0, 32'h80, 32'h0);
    push(1'b1, 1'b0, 32'h300, 32'h0);
    push(1'b0, 1'b0, 32'h80, 32'h0);
    push(1'b1, 1'b0, 32'h300, 32'h0);
    wait_done(3, LAT_A);
    wait_done(4, LAT_A);
    wait_done(4, LAT_A);
    wait_done(4, LAT_A);
    a_if_req = 1'b0; a_d_read = 1'b0;
    @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'h0);

    // reset during the second ACC cycle of a data read
    do_reset();
    a_d_read = 1'b1; a_d_addr = 32'h44;
    @(negedge clk);
    chk1("abort_acc0_en", a_mem_en, 1'b1);
    @(negedge clk);
    chk1("abort_acc1_en", a_mem_en, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk1("abort_busy", a_busy, 1'b0);
    chk1("abort_mem_en", a_mem_en, 1'b0);
    chk1("abort_d_ready", a_d_ready, 1'b0);
    chk("abort_d_rdata", a_d_rdata, 32'h0);
    a_d_read = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk1("abort_d_ready_late", a_d_ready, 1'b0);
    chk1("abort_busy_late", a_busy, 1'b0);

    // LATENCY=1 instance
    sel = 1'b1;
    #1;
    b_d_read = 1'b1; b_d_addr = 32'h20;
    push(1'b1, 1'b0, 32'h20, 32'h0);
    wait_done(2, LAT_B);
    b_d_read = 1'b0;
    @(negedge clk);
    b_d_read = 1'b1; b_d_write = 1'b1; b_d_addr = 32'h24; b_d_wdata = 32'h1234_5678;
    push(1'b1, 1'b1, 32'h24, 32'h1234_5678);
    wait_done(2, LAT_B);
    b_d_read = 1'b0; b_d_write = 1'b0;
    @(negedge clk);
    chk1("idle_b", b_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
